ovc_credit_tracker: RTL and testbench

Per-output-port tracker for V output virtual channels: keeps one credit counter per OVC and the OVC allocation status. Each OVC has its own credit capacity, and capacities can differ across VCs (heterogeneous depth). It loads initial credits from the control channel after reset, releases deferred VCs on a credit-release edge, masks VCs that the neighbouring router does not have, and flags protocol errors. It sits between the router's switch/VC allocators and the output link.

---
 rtl/ovc_credit_tracker.sv | 154 +++++++++++++++
 tb/tb_ovc_credit_tracker.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ovc_credit_tracker.sv
// Output-port credit tracker: one credit counter and one allocation bit per
// output virtual channel. Per-VC capacities come from the control channel
// during LOAD. VCs loaded with zero stay deferred until a release edge gives
// them the full depth B. Underflow and overflow are recorded in sticky bits.
module ovc_credit_tracker #(
  parameter int V              = 4,
  parameter int B              = 4,
  parameter int NF_TH          = 1,
  parameter bit OVC_ALLOC_MODE = 1'b1,
  parameter bit HETERO_EN      = 1'b0,
  localparam int CRDTw         = $clog2(B + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [V*CRDTw-1:0]   credit_init_val,
  input  logic [V-1:0]         credit_release_en,
  input  logic [V-1:0]         hetero_ovc_presence,
  input  logic                 flit_wr,
  input  logic [V-1:0]         flit_vc,
  input  logic [V-1:0]         credit_in,
  input  logic [V-1:0]         ovc_alloc,
  input  logic [V-1:0]         ovc_release,
  output logic [V*CRDTw-1:0]   credit,
  output logic [V-1:0]         full,
  output logic [V-1:0]         nearly_full,
  output logic [V-1:0]         empty,
  output logic [V-1:0]         status,
  output logic [V-1:0]         avalable,
  output logic                 init_done,
  output logic [V-1:0]         err_underflow,
  output logic [V-1:0]         err_overflow,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [CRDTw-1:0] B_C  = CRDTw'(B);
  localparam logic [CRDTw-1:0] NF_C = CRDTw'(NF_TH);

  state_t             state_q, state_d;
  logic [CRDTw-1:0]   cred  [V];
  logic [CRDTw-1:0]   cap   [V];
  logic [V-1:0]       deferred;
  logic [V-1:0]       rel_q;
  logic [V-1:0]       dec, inc, rise, at_zero, at_cap, present;

  // State register; reset may strike mid-traffic and forces a fresh reload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_INIT;
    else       state_q <= state_d;
  end

  // Next state: INIT and LOAD each last exactly one cycle, RUN is terminal.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: state_d = ST_LOAD;
      ST_LOAD: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // Per-VC event decode plus the counter comparisons shared by flags and updates.
  always_comb begin
    dec     = {V{flit_wr}} & flit_vc;
    inc     = credit_in;
    rise    = credit_release_en & ~rel_q;
    present = HETERO_EN ? hetero_ovc_presence : {V{1'b1}};
    at_zero = '0;
    at_cap  = '0;
    for (int v = 0; v < V; v++) begin
      at_zero[v] = (cred[v] == '0);
      at_cap[v]  = (cred[v] == cap[v]);
    end
  end

  // Credit, capacity, deferral, allocation and error state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int v = 0; v < V; v++) begin
        cred[v] <= '0;
        cap[v]  <= '0;
      end
      deferred      <= '0;
      rel_q         <= '0;
      status        <= '0;
      err_underflow <= '0;
      err_overflow  <= '0;
    end else begin
      // History keeps sampling through LOAD so a level held high there is not an edge.
      rel_q <= credit_release_en;
      if (state_q == ST_LOAD) begin
        for (int v = 0; v < V; v++) begin
          if (credit_init_val[v*CRDTw +: CRDTw] == '0) begin
            cred[v]     <= '0;
            cap[v]      <= '0;
            deferred[v] <= 1'b1;
          end else if (credit_init_val[v*CRDTw +: CRDTw] > B_C) begin
            cred[v]     <= B_C;
            cap[v]      <= B_C;
            deferred[v] <= 1'b0;
          end else begin
            cred[v]     <= credit_init_val[v*CRDTw +: CRDTw];
            cap[v]      <= credit_init_val[v*CRDTw +: CRDTw];
            deferred[v] <= 1'b0;
          end
        end
      end else if (state_q == ST_RUN) begin
        // Alloc wins over a simultaneous release: the next packet follows the tail.
        status <= ovc_alloc | (status & ~ovc_release);
        for (int v = 0; v < V; v++) begin
          // Errors are judged on the current count, deferred or not.
          if (dec[v] && !inc[v] && at_zero[v]) err_underflow[v] <= 1'b1;
          if (inc[v] && !dec[v] && at_cap[v])  err_overflow[v]  <= 1'b1;
          if (deferred[v]) begin
            if (rise[v]) begin
              cred[v]     <= B_C;
              cap[v]      <= B_C;
              deferred[v] <= 1'b0;
            end
          end else if (dec[v] && !inc[v] && !at_zero[v]) begin
            cred[v] <= cred[v] - 1'b1;
          end else if (inc[v] && !dec[v] && !at_cap[v]) begin
            cred[v] <= cred[v] + 1'b1;
          end
        end
      end
    end
  end

  // Flags and availability are pure decodes of registered state.
  always_comb begin
    credit      = '0;
    full        = '0;
    nearly_full = '0;
    empty       = '0;
    for (int v = 0; v < V; v++) begin
      credit[v*CRDTw +: CRDTw] = cred[v];
      full[v]        = at_zero[v];
      nearly_full[v] = (cred[v] <= NF_C);
      empty[v]       = at_cap[v];
    end
    init_done = (state_q == ST_RUN);
    dbg_state = state_q;
    avalable  = {V{init_done}} & present & ~deferred & ~status &
                (OVC_ALLOC_MODE ? ~full : ~nearly_full);
  end

endmodule

// File: tb/tb_ovc_credit_tracker.sv
// Directed bench for ovc_credit_tracker. Instance a uses the default
// parameters; instance b shares all stimulus but runs OVC_ALLOC_MODE=0 and
// HETERO_EN=1 with VC3 absent at the neighbour.
module tb_ovc_credit_tracker;

  localparam int V = 4;
  localparam int B = 4;
  localparam int W = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [V*W-1:0] credit_init_val;
  logic [V-1:0]   credit_release_en, hetero_ovc_presence;
  logic           flit_wr;
  logic [V-1:0]   flit_vc, credit_in, ovc_alloc, ovc_release;

  logic [V*W-1:0] credit_a, credit_b;
  logic [V-1:0]   full_a, nf_a, empty_a, status_a, av_a, uf_a, of_a;
  logic [V-1:0]   full_b, nf_b, empty_b, status_b, av_b, uf_b, of_b;
  logic           done_a, done_b;
  logic [1:0]     st_a, st_b;

  int n_cmp = 0;
  int n_err = 0;

  // Clock: 10 ns period, posedge active.
  always #5 clk = ~clk;

  ovc_credit_tracker #(.V(V), .B(B)) dut_a (
    .clk(clk), .reset(reset), .credit_init_val(credit_init_val),
    .credit_release_en(credit_release_en), .hetero_ovc_presence(hetero_ovc_presence),
    .flit_wr(flit_wr), .flit_vc(flit_vc), .credit_in(credit_in),
    .ovc_alloc(ovc_alloc), .ovc_release(ovc_release),
    .credit(credit_a), .full(full_a), .nearly_full(nf_a), .empty(empty_a),
    .status(status_a), .avalable(av_a), .init_done(done_a),
    .err_underflow(uf_a), .err_overflow(of_a), .dbg_state(st_a)
  );

  ovc_credit_tracker #(.V(V), .B(B), .OVC_ALLOC_MODE(1'b0), .HETERO_EN(1'b1)) dut_b (
    .clk(clk), .reset(reset), .credit_init_val(credit_init_val),
    .credit_release_en(credit_release_en), .hetero_ovc_presence(hetero_ovc_presence),
    .flit_wr(flit_wr), .flit_vc(flit_vc), .credit_in(credit_in),
    .ovc_alloc(ovc_alloc), .ovc_release(ovc_release),
    .credit(credit_b), .full(full_b), .nearly_full(nf_b), .empty(empty_b),
    .status(status_b), .avalable(av_b), .init_done(done_b),
    .err_underflow(uf_b), .err_overflow(of_b), .dbg_state(st_b)
  );

  function automatic logic [V*W-1:0] pk(input int c0, input int c1, input int c2, input int c3);
    return {W'(c3), W'(c2), W'(c1), W'(c0)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle 1 ns so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset               = 1'b1;
    credit_init_val     = pk(4, 3, 0, 2);
    credit_release_en   = '0;
    hetero_ovc_presence = 4'b0111;
    flit_wr             = 1'b0;
    flit_vc             = '0;
    credit_in           = '0;
    ovc_alloc           = '0;
    ovc_release         = '0;

    // Reset state
    tick(); tick();
    chk("rst_credit", 32'(credit_a), 32'(pk(0, 0, 0, 0)));
    chk("rst_full", 32'(full_a), 32'hF);
    chk("rst_nf", 32'(nf_a), 32'hF);
    chk("rst_empty", 32'(empty_a), 32'hF);
    chk("rst_avail", 32'(av_a), 32'h0);
    chk("rst_done", 32'(done_a), 32'h0);
    chk("rst_state", 32'(st_a), 32'h0);

    // Load sequence: INIT -> LOAD -> RUN
    reset = 1'b0;
    tick();
    chk("load_state", 32'(st_a), 32'h1);
    chk("load_done", 32'(done_a), 32'h0);
    tick();
    chk("run_done", 32'(done_a), 32'h1);
    chk("run_credit", 32'(credit_a), 32'(pk(4, 3, 0, 2)));
    chk("run_full", 32'(full_a), 32'b0100);
    chk("run_nf", 32'(nf_a), 32'b0100);
    chk("run_empty", 32'(empty_a), 32'hF);
    chk("run_avail_a", 32'(av_a), 32'b1011);
    chk("run_avail_b", 32'(av_b), 32'b0011);

    // Release deferred VC2, then a second edge must be ignored
    credit_release_en = 4'b0100;
    tick();
    chk("rel_credit", 32'(credit_a), 32'(pk(4, 3, 4, 2)));
    chk("rel_empty", 32'(empty_a), 32'hF);
    chk("rel_avail_a", 32'(av_a), 32'hF);
    chk("rel_avail_b", 32'(av_b), 32'b0111);
    credit_release_en = 4'b0000;
    tick();
    credit_release_en = 4'b0100;
    tick();
    chk("rel2_credit", 32'(credit_a), 32'(pk(4, 3, 4, 2)));
    chk("rel2_of", 32'(of_a), 32'h0);
    credit_release_en = 4'b0000;

    // Drain VC0 to zero then underflow it
    flit_wr = 1'b1; flit_vc = 4'b0001;
    tick();
    chk("drain3_credit", 32'(credit_a), 32'(pk(3, 3, 4, 2)));
    chk("drain3_nf", 32'(nf_a), 32'h0);
    tick();
    chk("drain2_credit", 32'(credit_a), 32'(pk(2, 3, 4, 2)));
    tick();
    chk("drain1_credit", 32'(credit_a), 32'(pk(1, 3, 4, 2)));
    chk("drain1_nf", 32'(nf_a), 32'b0001);
    chk("drain1_full", 32'(full_a), 32'h0);
    chk("drain1_avail_a", 32'(av_a), 32'hF);
    chk("drain1_avail_b", 32'(av_b), 32'b0110);
    tick();
    chk("drain0_credit", 32'(credit_a), 32'(pk(0, 3, 4, 2)));
    chk("drain0_full", 32'(full_a), 32'b0001);
    chk("drain0_avail_a", 32'(av_a), 32'b1110);
    chk("drain0_uf", 32'(uf_a), 32'h0);
    tick();
    chk("uf_credit", 32'(credit_a), 32'(pk(0, 3, 4, 2)));
    chk("uf_flag", 32'(uf_a), 32'b0001);

    // VC1: down to 1, simultaneous inc/dec, refill, then overflow
    flit_vc = 4'b0010;
    tick(); tick();
    chk("vc1_credit1", 32'(credit_a), 32'(pk(0, 1, 4, 2)));
    credit_in = 4'b0010;
    tick();
    chk("incdec_credit", 32'(credit_a), 32'(pk(0, 1, 4, 2)));
    chk("incdec_of", 32'(of_a), 32'h0);
    chk("incdec_uf", 32'(uf_a), 32'b0001);
    flit_wr = 1'b0; flit_vc = '0;
    tick(); tick();
    chk("refill_credit", 32'(credit_a), 32'(pk(0, 3, 4, 2)));
    chk("refill_empty", 32'(empty_a), 32'b1110);
    tick();
    chk("of_credit", 32'(credit_a), 32'(pk(0, 3, 4, 2)));
    chk("of_flag", 32'(of_a), 32'b0010);
    credit_in = '0;

    // Allocation status on VC3
    ovc_alloc = 4'b1000;
    tick();
    chk("alloc_status", 32'(status_a), 32'b1000);
    chk("alloc_avail", 32'(av_a), 32'b0110);
    ovc_release = 4'b1000;
    tick();
    chk("allocrel_status", 32'(status_a), 32'b1000);
    chk("allocrel_avail", 32'(av_a), 32'b0110);
    ovc_alloc = '0;
    tick();
    chk("release_status", 32'(status_a), 32'b0000);
    chk("release_avail", 32'(av_a), 32'b1110);
    ovc_release = '0;

    // VC3 down to 1: mode 1 still allocatable, mode 0 / absent VC is not
    flit_wr = 1'b1; flit_vc = 4'b1000;
    tick();
    chk("vc3_credit", 32'(credit_a), 32'(pk(0, 3, 4, 1)));
    chk("vc3_avail_a", 32'(av_a), 32'b1110);
    chk("vc3_avail_b", 32'(av_b), 32'b0110);
    chk("vc3_nf_b", 32'(nf_b), 32'b1001);

    // Mid-traffic asynchronous reset
    flit_vc = 4'b0100;
    tick();
    chk("pre_rst_credit", 32'(credit_a), 32'(pk(0, 3, 3, 1)));
    reset = 1'b1;
    #1;
    chk("arst_credit", 32'(credit_a), 32'(pk(0, 0, 0, 0)));
    chk("arst_full", 32'(full_a), 32'hF);
    chk("arst_nf", 32'(nf_a), 32'hF);
    chk("arst_empty", 32'(empty_a), 32'hF);
    chk("arst_avail", 32'(av_a), 32'h0);
    chk("arst_uf", 32'(uf_a), 32'h0);
    chk("arst_of", 32'(of_a), 32'h0);
    chk("arst_status", 32'(status_a), 32'h0);
    chk("arst_done", 32'(done_a), 32'h0);

    // Reload with a saturating value and release held high across LOAD
    flit_wr = 1'b0; flit_vc = '0;
    credit_init_val   = pk(7, 1, 0, 4);
    credit_release_en = 4'b0100;
    tick();
    reset = 1'b0;
    tick(); tick();
    chk("reload_done", 32'(done_a), 32'h1);
    chk("reload_credit", 32'(credit_a), 32'(pk(4, 1, 0, 4)));
    chk("reload_full", 32'(full_a), 32'b0100);
    chk("reload_nf", 32'(nf_a), 32'b0110);
    chk("reload_avail_a", 32'(av_a), 32'b1011);
    chk("reload_avail_b", 32'(av_b), 32'b0001);
    chk("reload_credit_b", 32'(credit_b), 32'(pk(4, 1, 0, 4)));

    // Level held from LOAD is no edge; credit into a deferred VC overflows
    credit_in = 4'b0100;
    tick();
    chk("held_credit", 32'(credit_a), 32'(pk(4, 1, 0, 4)));
    chk("defer_of", 32'(of_a), 32'b0100);
    credit_in = '0;
    credit_release_en = 4'b0000;
    tick();
    credit_release_en = 4'b0100;
    tick();
    chk("rel3_credit", 32'(credit_a), 32'(pk(4, 1, 4, 4)));
    chk("rel3_avail_a", 32'(av_a), 32'hF);
    chk("rel3_avail_b", 32'(av_b), 32'b0101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
